// File: rtl/adpll_lock_detect.sv
// rtl/adpll_lock_detect.sv - ADPLL lock detector: ref/fb edge sync, fb-per-ref window count, lock FSM
module adpll_lock_detect #(
    parameter int LOCK_CYCLES   = 8,
    parameter int UNLOCK_CYCLES = 2,
    parameter int TIMEOUT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_ref,
    input  logic       fb_clk,
    input  logic [4:0] filter_out,
    input  logic       filter_sign,
    input  logic [4:0] lock_thresh,
    input  logic       clr,
    output logic       lock,
    output logic       lost,
    output logic [1:0] state,
    output logic [3:0] fb_per_ref
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_UNUSED = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_N   = 4'(LOCK_CYCLES);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CYCLES);

    // bit0 = first sync flop, bit1 = second sync flop, bit2 = edge history
    logic [2:0]           ref_sync_q, fb_sync_q;
    state_t               state_q, state_d;
    logic [3:0]           good_cnt_q, good_cnt_d;
    logic [3:0]           bad_cnt_q, bad_cnt_d;
    logic                 lock_q, lock_d;
    logic                 lost_q, lost_d;
    logic [3:0]           fb_cnt_q, fb_cnt_d;
    logic [3:0]           fb_per_ref_q, fb_per_ref_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

    logic ref_edge, fb_edge, tmo_full, good_win;
    logic unused_sign;

    assign unused_sign = filter_sign;
    assign ref_edge    = ref_sync_q[1] & ~ref_sync_q[2];
    assign fb_edge     = fb_sync_q[1] & ~fb_sync_q[2];
    assign tmo_full    = &tmo_q;
    // The sign is deliberately ignored: only the magnitude of the filter output matters.
    assign good_win    = (fb_cnt_q == 4'd1) && (filter_out <= lock_thresh);

    always_comb begin
        fb_per_ref_d = fb_per_ref_q;
        fb_cnt_d     = fb_cnt_q;
        if (ref_edge) begin
            fb_per_ref_d = fb_cnt_q;
            fb_cnt_d     = {3'b000, fb_edge};
        end else if (fb_edge && (fb_cnt_q != 4'hF)) begin
            fb_cnt_d = fb_cnt_q + 4'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        lock_d     = lock_q;
        lost_d     = clr ? 1'b0 : lost_q;
        tmo_d      = ref_edge ? '0 : tmo_q + 1'b1;

        if (tmo_full) begin
            if (state_q == ST_LOCKED) begin
                lost_d = 1'b1;
            end
            state_d = ST_IDLE;
            lock_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    lock_d = 1'b0;
                    if (ref_edge) begin
                        state_d    = ST_ACQ;
                        good_cnt_d = 4'd0;
                    end
                end
                ST_ACQ: begin
                    if (ref_edge) begin
                        if (!good_win) begin
                            good_cnt_d = 4'd0;
                        end else if (good_cnt_q + 4'd1 == LOCK_N) begin
                            state_d   = ST_LOCKED;
                            lock_d    = 1'b1;
                            bad_cnt_d = 4'd0;
                        end else begin
                            good_cnt_d = good_cnt_q + 4'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (ref_edge) begin
                        if (good_win) begin
                            bad_cnt_d = 4'd0;
                        end else if (bad_cnt_q + 4'd1 == UNLOCK_N) begin
                            state_d    = ST_ACQ;
                            lock_d     = 1'b0;
                            lost_d     = 1'b1;
                            good_cnt_d = 4'd0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    lock_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_sync_q   <= 3'b000;
            fb_sync_q    <= 3'b000;
            state_q      <= ST_IDLE;
            good_cnt_q   <= 4'd0;
            bad_cnt_q    <= 4'd0;
            lock_q       <= 1'b0;
            lost_q       <= 1'b0;
            fb_cnt_q     <= 4'd0;
            fb_per_ref_q <= 4'd0;
            tmo_q        <= '0;
        end else begin
            ref_sync_q   <= {ref_sync_q[1:0], clk_ref};
            fb_sync_q    <= {fb_sync_q[1:0], fb_clk};
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            lock_q       <= lock_d;
            lost_q       <= lost_d;
            fb_cnt_q     <= fb_cnt_d;
            fb_per_ref_q <= fb_per_ref_d;
            tmo_q        <= tmo_d;
        end
    end

    assign lock       = lock_q;
    assign lost       = lost_q;
    assign state      = state_q;
    assign fb_per_ref = fb_per_ref_q;
endmodule

// File: tb/tb_adpll_lock_detect.sv
// tb/tb_adpll_lock_detect.sv - self-checking bench for adpll_lock_detect
`timescale 1ns/1ps
module tb_adpll_lock_detect;
    localparam int LOCK_N   = 8;
    localparam int UNLOCK_N = 2;
    localparam int TMO      = 255;

    logic       clk = 1'b0, rst_n = 1'b0, clk_ref = 1'b0, fb_clk = 1'b0;
    logic       filter_sign = 1'b0, clr = 1'b0;
    logic [4:0] filter_out = 5'd0, lock_thresh = 5'd0;
    logic       lock, lost;
    logic [1:0] state;
    logic [3:0] fb_per_ref;

    int n_checks = 0, n_fail = 0;

    int t_cyc = 0, ref_per = 20, ref_off = 5, fb_per = 20, fb_off = 8;
    bit ref_en = 1'b1, fb_en = 1'b1;

    int m_state, m_good, m_bad, m_fbraw, m_fbper, m_since, n_ref;
    bit m_lock, m_lost, m_rev;
    bit rh[3], fh[3];

    adpll_lock_detect dut (
        .clk(clk), .rst_n(rst_n), .clk_ref(clk_ref), .fb_clk(fb_clk),
        .filter_out(filter_out), .filter_sign(filter_sign), .lock_thresh(lock_thresh),
        .clr(clr), .lock(lock), .lost(lost), .state(state), .fb_per_ref(fb_per_ref)
    );

    always #5 clk = ~clk;

    function automatic bit pin_at(int t, int per, int off);
        int r;
        r = t - off;
        return (r >= 0) && ((r % per) < (per / 2));
    endfunction

    // Reference model: pins seen two samples late, windows counted with unbounded ints.
    task automatic model_update();
        bit rev, fev, good;
        if (!rst_n) begin
            m_state = 0; m_good = 0; m_bad = 0; m_fbraw = 0; m_fbper = 0;
            m_since = 0; m_lock = 0; m_lost = 0; m_rev = 0; n_ref = 0;
            rh = '{default: 1'b0};
            fh = '{default: 1'b0};
            return;
        end
        rev  = rh[1] && !rh[2];
        fev  = fh[1] && !fh[2];
        good = (m_fbraw == 1) && (filter_out <= lock_thresh);
        if (clr) m_lost = 0;
        if (m_since == TMO) begin
            if (m_state == 2) m_lost = 1;
            m_state = 0; m_lock = 0;
        end else if (rev) begin
            if (m_state == 0) begin
                m_state = 1; m_good = 0;
            end else if (m_state == 1) begin
                if (!good) m_good = 0;
                else if (m_good + 1 == LOCK_N) begin m_state = 2; m_lock = 1; m_bad = 0; end
                else m_good++;
            end else begin
                if (good) m_bad = 0;
                else if (m_bad + 1 == UNLOCK_N) begin
                    m_state = 1; m_lock = 0; m_lost = 1; m_good = 0;
                end else m_bad++;
            end
        end
        if (rev) begin
            m_fbper = (m_fbraw > 15) ? 15 : m_fbraw;
            m_fbraw = fev;
            n_ref++;
        end else begin
            m_fbraw += fev;
        end
        m_since = rev ? 0 : (m_since + 1) % (TMO + 1);
        m_rev = rev;
        rh[2] = rh[1]; rh[1] = rh[0]; rh[0] = clk_ref;
        fh[2] = fh[1]; fh[1] = fh[0]; fh[0] = fb_clk;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        t_cyc++;
        @(negedge clk);
        clk_ref = ref_en && pin_at(t_cyc, ref_per, ref_off);
        fb_clk  = fb_en && pin_at(t_cyc, fb_per, fb_off);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) step();
        t_cyc = 0; clk_ref = 1'b0; fb_clk = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ref_per = 2; ref_off = 0; fb_per = 2; fb_off = 1;
        rst_n = 1'b0;
        repeat (3) step();
        n_checks += 4;
        if (lock !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b expected 0", lock); end
        if (lost !== 1'b0) begin n_fail++; $display("FAIL reset_lost: got %b expected 0", lost); end
        if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        if (fb_per_ref !== 4'd0) begin n_fail++; $display("FAIL reset_fbpr: got %0d expected 0", fb_per_ref); end
        ref_per = 20; ref_off = 5; fb_per = 20; fb_off = 8;
        t_cyc = 0; clk_ref = 1'b0; fb_clk = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 100 && n_ref < 1; i++) step();
        n_checks++;
        if (state !== 2'd1) begin n_fail++; $display("FAIL reset_first_edge_state: got %0d expected 1", state); end
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        n_checks += 2;
        if (state !== 2'd1) begin n_fail++; $display("FAIL reset_not_async: got state %0d expected 1", state); end
        if (state !== 2'(m_state)) begin n_fail++; $display("FAIL reset_model_state: got %0d expected %0d", state, m_state); end
    endtask

    task automatic test_acquire();
        int early;
        bit seen_acq;
        early = 0; seen_acq = 0;
        ref_per = 20; ref_off = 5; fb_per = 20; fb_off = 8; ref_en = 1; fb_en = 1;
        filter_out = 5'd2; lock_thresh = 5'd4;
        apply_reset();
        for (int i = 0; i < 400 && n_ref < 9; i++) begin
            step();
            if (n_ref == 1 && m_rev) begin
                seen_acq = 1;
                n_checks++;
                if (state !== 2'd1) begin n_fail++; $display("FAIL acq_state_after_first: got %0d expected 1", state); end
            end
            if (n_ref < 9 && lock !== 1'b0) early++;
        end
        n_checks += 6;
        if (!seen_acq) begin n_fail++; $display("FAIL acq_first_edge_seen: got 0 expected 1"); end
        if (n_ref != 9) begin n_fail++; $display("FAIL acq_edge_budget: got %0d edges expected 9", n_ref); end
        if (early != 0) begin n_fail++; $display("FAIL acq_early_lock: got %0d cycles expected 0", early); end
        if (lock !== 1'b1) begin n_fail++; $display("FAIL acq_lock_at_9: got %b expected 1", lock); end
        if (fb_per_ref !== 4'd1) begin n_fail++; $display("FAIL acq_fbpr: got %0d expected 1", fb_per_ref); end
        if (state !== 2'd2) begin n_fail++; $display("FAIL acq_state_locked: got %0d expected 2", state); end
    endtask

    task automatic test_threshold();
        int early;
        logic lock_at9;
        early = 0; lock_at9 = 1'bx;
        filter_out = 5'd2; lock_thresh = 5'd4;
        apply_reset();
        for (int i = 0; i < 600 && n_ref < 14; i++) begin
            step();
            filter_out = (n_ref == 5) ? 5'd5 : 5'd2;
            if (n_ref == 9 && m_rev) lock_at9 = lock;
            if (n_ref < 14 && lock !== 1'b0) early++;
        end
        n_checks += 4;
        if (n_ref != 14) begin n_fail++; $display("FAIL thr_edge_budget: got %0d edges expected 14", n_ref); end
        if (lock_at9 !== 1'b0) begin n_fail++; $display("FAIL thr_lock_at_9: got %b expected 0", lock_at9); end
        if (early != 0) begin n_fail++; $display("FAIL thr_early_lock: got %0d cycles expected 0", early); end
        if (lock !== 1'b1) begin n_fail++; $display("FAIL thr_lock_at_14: got %b expected 1", lock); end
    endtask

    task automatic test_unlock();
        int n_sw, n_unl;
        n_sw = n_ref;
        fb_per = 10;
        for (int i = 0; i < 200 && lock !== 1'b0; i++) step();
        n_unl = n_ref;
        n_checks += 4;
        if (n_unl != n_sw + 2) begin n_fail++; $display("FAIL unl_edges: got %0d expected %0d", n_unl, n_sw + 2); end
        if (lost !== 1'b1) begin n_fail++; $display("FAIL unl_lost: got %b expected 1", lost); end
        if (state !== 2'd1) begin n_fail++; $display("FAIL unl_state: got %0d expected 1", state); end
        if (fb_per_ref !== 4'd2) begin n_fail++; $display("FAIL unl_fbpr: got %0d expected 2", fb_per_ref); end
        fb_per = 20;
        for (int i = 0; i < 400 && lock !== 1'b1; i++) step();
        n_checks += 2;
        if (n_ref != n_unl + 8) begin n_fail++; $display("FAIL relock_edges: got %0d expected %0d", n_ref, n_unl + 8); end
        if (lost !== 1'b1) begin n_fail++; $display("FAIL relock_lost_sticky: got %b expected 1", lost); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_checks += 2;
        if (lost !== 1'b0) begin n_fail++; $display("FAIL clr_lost: got %b expected 0", lost); end
        if (lock !== 1'b1) begin n_fail++; $display("FAIL clr_keeps_lock: got %b expected 1", lock); end
    endtask

    task automatic test_timeout();
        int n0;
        logic [1:0] st255;
        for (int i = 0; i < 60 && !m_rev; i++) step();
        ref_en = 0;
        for (int k = 1; k <= 255; k++) step();
        st255 = state;
        step();
        n_checks += 4;
        if (st255 !== 2'd2) begin n_fail++; $display("FAIL tmo_state_before: got %0d expected 2", st255); end
        if (state !== 2'd0) begin n_fail++; $display("FAIL tmo_state: got %0d expected 0", state); end
        if (lock !== 1'b0) begin n_fail++; $display("FAIL tmo_lock: got %b expected 0", lock); end
        if (lost !== 1'b1) begin n_fail++; $display("FAIL tmo_lost: got %b expected 1", lost); end
        n0 = n_ref;
        ref_en = 1;
        for (int i = 0; i < 60 && n_ref == n0; i++) step();
        n_checks += 2;
        if (n_ref != n0 + 1) begin n_fail++; $display("FAIL tmo_resume_edge: got %0d expected %0d", n_ref, n0 + 1); end
        if (state !== 2'd1) begin n_fail++; $display("FAIL tmo_resume_state: got %0d expected 1", state); end
    endtask

    task automatic test_coincident();
        int n0;
        ref_per = 20; ref_off = 5; fb_per = 20; fb_off = 5;
        filter_out = 5'd1; lock_thresh = 5'd3;
        apply_reset();
        for (int i = 0; i < 400 && n_ref < 9; i++) step();
        n_checks += 3;
        if (n_ref != 9) begin n_fail++; $display("FAIL coin_edge_budget: got %0d expected 9", n_ref); end
        if (lock !== 1'b1) begin n_fail++; $display("FAIL coin_lock: got %b expected 1", lock); end
        if (fb_per_ref !== 4'd1) begin n_fail++; $display("FAIL coin_fbpr: got %0d expected 1", fb_per_ref); end
        ref_per = 40; fb_per = 2; fb_off = 0;
        n0 = n_ref;
        for (int i = 0; i < 600 && n_ref < n0 + 6; i++) step();
        n_checks += 4;
        if (n_ref != n0 + 6) begin n_fail++; $display("FAIL sat_edge_budget: got %0d expected %0d", n_ref, n0 + 6); end
        if (fb_per_ref !== 4'd15) begin n_fail++; $display("FAIL sat_fbpr: got %0d expected 15", fb_per_ref); end
        if (lock !== 1'b0) begin n_fail++; $display("FAIL sat_lock: got %b expected 0", lock); end
        if (state !== 2'd1) begin n_fail++; $display("FAIL sat_state: got %0d expected 1", state); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int seg = 0; seg < 8; seg++) begin
            ref_per = $urandom_range(12, 40);
            case ($urandom % 3)
                0: fb_per = ref_per;
                1: fb_per = ref_per / 2;
                default: fb_per = $urandom_range(2, 60);
            endcase
            ref_off = $urandom_range(0, 30);
            fb_off  = $urandom_range(0, 30);
            ref_en  = ($urandom % 5) != 0;
            lock_thresh = 5'($urandom_range(3, 28));
            for (int c = 0; c < 300; c++) begin
                filter_out  = (($urandom % 6) == 0) ? 5'($urandom % 32) : (lock_thresh >> 1);
                filter_sign = 1'($urandom);
                clr         = (($urandom % 64) == 0);
                step();
                n_checks += 4;
                if (lock !== m_lock) begin n_fail++; $display("FAIL rnd_lock t=%0d: got %b expected %b", t_cyc, lock, m_lock); end
                if (lost !== m_lost) begin n_fail++; $display("FAIL rnd_lost t=%0d: got %b expected %b", t_cyc, lost, m_lost); end
                if (state !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state t=%0d: got %0d expected %0d", t_cyc, state, m_state); end
                if (fb_per_ref !== 4'(m_fbper)) begin n_fail++; $display("FAIL rnd_fbpr t=%0d: got %0d expected %0d", t_cyc, fb_per_ref, m_fbper); end
            end
        end
        clr = 1'b0;
        ref_en = 1;
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_threshold();
        test_unlock();
        test_timeout();
        test_coincident();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
